// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/decode datapath.
// Holds the FSM state codes, instruction field positions and PC arithmetic helpers.
package cpu_pkg;

   typedef logic [31:0] word_t;
   typedef logic [1:0]  state_t;

   localparam state_t FETCH  = 2'd0;
   localparam state_t ISSUE  = 2'd1;
   localparam state_t HALTED = 2'd2;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int FUNC_MSB = 5;
   localparam int IMM_MSB  = 15;

   localparam word_t      PC_INC    = 32'd4;
   localparam logic [5:0] OPC_SHIFT = 6'b000010;

   function automatic word_t word_align(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bundle.
// The master drives req/addr; the slave returns a one-cycle ack with rdata.
interface instruction_fetch_if;
   import cpu_pkg::*;

   logic  imem_req;
   word_t imem_addr;
   logic  imem_ack;
   word_t imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/instr_field_decode.sv
// Combinational splitter of the instruction register into opcode, function and 16-bit low field.
// Zero latency, no state, no backpressure.
module instr_field_decode
   import cpu_pkg::*;
(
   input  word_t       instr,
   output logic [5:0]  op_code,
   output logic [5:0]  func_code,
   output logic [15:0] imm_field
);

   assign op_code   = instr[OPC_MSB:OPC_LSB];
   assign func_code = instr[FUNC_MSB:0];
   assign imm_field = instr[IMM_MSB:0];

   // Register/shamt fields in the middle are consumed further down the decode stage.
   logic unused_mid;
   assign unused_mid = ^instr[OPC_LSB-1:IMM_MSB+1];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem handshake and instruction register; one instruction per two cycles with zero-wait memory.
// Holds the instruction while stall=1; optional fetch watchdog under FETCH_TIMEOUT_EN.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter word_t RESET_PC       = 32'h0000_0000,
   parameter int    TIMEOUT_CYCLES = 15
)(
   input  logic                clk,
   input  logic                rst,
   instruction_fetch_if.master imem,
   input  logic                stall,
   input  logic                branch_taken,
   input  word_t               branch_target,
   input  logic                halt,
   output logic                instr_valid,
   output word_t               instr,
   output logic [5:0]          OP_CODE,
   output logic [5:0]          FUNC_CODE,
   output logic [15:0]         imm_field,
   output word_t               pc_out,
   output logic                halted,
   output logic                fetch_error
);

   state_t state;
   word_t  pc;
   logic   fetch_armed;
   logic   fetch_active;
   logic   timeout_hit;

   // Reset clears fetch_armed, so the request drops the moment reset asserts
   // and only returns at the first edge after release.
   assign fetch_active   = fetch_armed && (state == FETCH);
   assign imem.imem_req  = fetch_active;
   assign imem.imem_addr = pc;
   assign pc_out         = pc;
   assign halted         = (state == HALTED);

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt;

   assign timeout_hit = fetch_active && !imem.imem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt    <= '0;
         fetch_error <= 1'b0;
      end else begin
         if (state != FETCH)
            wait_cnt <= '0;
         else if (fetch_active && !imem.imem_ack && !timeout_hit)
            wait_cnt <= wait_cnt + 1'b1;
         if (timeout_hit)
            fetch_error <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign fetch_error = 1'b0;

   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FETCH;
         fetch_armed <= 1'b0;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         fetch_armed <= 1'b1;
         case (state)
            FETCH: begin
               if (fetch_active && imem.imem_ack) begin
                  instr       <= imem.imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= ISSUE;
               end else if (timeout_hit) begin
                  state <= HALTED;
               end
            end
            ISSUE: begin
               if (!stall) begin
                  instr_valid <= 1'b0;
                  pc          <= branch_taken ? word_align(branch_target) : pc + PC_INC;
                  state       <= halt ? HALTED : FETCH;
               end
            end
            HALTED: ;
            default: state <= FETCH;
         endcase
      end
   end

   instr_field_decode u_decode (
      .instr     (instr),
      .op_code   (OP_CODE),
      .func_code (FUNC_CODE),
      .imm_field (imm_field)
   );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the single-cycle-issue CPU datapath.
- Drives the PC and runs a request/acknowledge handshake with instruction memory.
- Latches each returned word into an instruction register and presents the decoded fields (OP_CODE, FUNC_CODE, low 16 bits) to the decode stage, which includes the immediate/shift-amount sign extender.
- Holds the instruction while decode stalls, and applies branch redirects and halts when an instruction retires.

## Interface
- Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; low two bits must be 00.
- TIMEOUT_CYCLES, 15: maximum FETCH cycles without imem_ack. Used only with FETCH_TIMEOUT_EN.
- Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, high exactly while in FETCH.
- imem_addr  out  32  byte address, equal to the PC.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode not ready; the held instruction is not consumed.
- branch_taken  in  1  redirect request, sampled only on a consume cycle.
- branch_target  in  32  redirect address; bits [1:0] forced to 00.
- halt  in  1  stop after the current instruction, sampled only on a consume cycle.
- instr_valid  out  1  the instruction register holds an unconsumed instruction.
- instr  out  32  the instruction register.
- OP_CODE  out  6  instr[31:26].
- FUNC_CODE  out  6  instr[5:0].
- imm_field  out  16  instr[15:0].
- pc_out  out  32  PC of the held instruction.
- halted  out  1  block is in HALTED.
- fetch_error  out  1  timeout occurred (sticky); tied to 0 without FETCH_TIMEOUT_EN.

## Operation
- States:
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, go to ISSUE.
  - Otherwise stay in FETCH.
- ISSUE: instruction is presented.
  - A cycle with stall=0 is a consume cycle:
    - instr_valid<=0.
    - pc <= branch_taken ? {branch_target[31:2],2'b00} : pc+4.
    - Go to HALTED if halt=1, else to FETCH.
  - With stall=1: all registers hold.
- HALTED: terminal until reset. imem_req=0, instr_valid=0, halted=1.
- Decoded fields are combinational slices of instr and are stable while instr is held.
- pc_out equals the PC used for the fetch of the held instruction; it is not updated until the consume edge.
- Boundary conditions:
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- imem_ack outside FETCH is ignored; no state change.
- branch_taken and halt are ignored outside consume cycles.
- When halt and branch_taken are both set on a consume cycle: the redirected PC is loaded, then HALTED.
- Reset asserted mid-fetch abandons the request immediately. imem_req drops asynchronously and no rdata is captured.

## Timing
- Reset values (while rst=0):
- State FETCH; imem_req held 0 during reset.
- pc=RESET_PC; instr=0, so OP_CODE=0, FUNC_CODE=0, imm_field=0.
- instr_valid=0, pc_out=RESET_PC, halted=0, fetch_error=0.
- imem_req=1 from the first clock edge after reset deassertion.
- Fetch latency: an ack in cycle N gives instr_valid=1 in cycle N+1.
- With a zero-wait memory (ack in the same cycle as req) and no stall, one instruction issues every 2 cycles.
- Consume at edge N gives imem_req=1 with the new imem_addr in cycle N+1.

## Configuration
- FETCH_TIMEOUT_EN defined:
- A 4-bit+ wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
- When it reaches TIMEOUT_CYCLES, at the next edge: fetch_error<=1 and go to HALTED.
- Undefined: no counter; FETCH waits indefinitely; fetch_error is constant 0.

## Structure
- Shared package cpu_pkg holds:
- State enum {FETCH, ISSUE, HALTED}.
- Field bit-position constants: OPC_MSB=31, OPC_LSB=26, FUNC_MSB=5, IMM_MSB=15.
- PC_INC=4.
- OPC_SHIFT=6'b000010.
- One sub-module, instr_field_decode: a combinational splitter from instr to OP_CODE/FUNC_CODE/imm_field.
- FSM, PC and instruction register stay in instruction_fetch.

## Test plan
- Reset then zero-wait memory returning 32'h0800_F803: imem_addr=0 with req in cycle 1; instr_valid in cycle 2 with OP_CODE=6'b000010, imm_field=16'hF803, FUNC_CODE=6'b000011; next imem_addr=4.
- Hold stall=1 for 5 cycles in ISSUE: instr, pc_out and instr_valid stable; imem_req=0; after stall drops, the next fetch goes to pc_out+4.
- Consume with branch_taken=1, branch_target=32'h0000_0103: next imem_addr=32'h0000_0100.
- RESET_PC=32'hFFFF_FFFC, consume once: next imem_addr=0.
- Consume with halt=1 and branch_taken=1: halted=1, imem_req=0 permanently; ack pulses ignored.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=15, no ack: fetch_error=1 and halted=1 after 15 FETCH cycles. Without the macro: still in FETCH at cycle 100. Reset mid-wait clears both outputs.
